hex_uart_tx: RTL

Transmits a 16-bit value as four ASCII hex characters followed by CR LF over an 8N1 UART line. It sits beside the four random-number generators on the DE2-115 top level. When a draw finishes, the top level pulses `i_start` with the four displayed nibbles, and this block drives `UART_TXD` so the host sees the same digits the seven-segment displays show. It is the off-board transmit end of the result path.

---
 rtl/hex_uart_tx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hex_uart_tx.sv
// Sends a 16-bit value as four ASCII hex characters plus CR LF on an 8N1 UART line.
// Bytes are sent back-to-back, and every output is driven straight from a flop.
module hex_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_digits,
  output logic        o_txd,
  output logic        o_idle,
  output logic        o_done,
  output logic [1:0]  dbg_state
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [15:0]   digits;
  logic [7:0]    cur_byte;
  logic          bit_end;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx)
      3'd0:    cur_byte = hex_ascii(digits[15:12]);
      3'd1:    cur_byte = hex_ascii(digits[11:8]);
      3'd2:    cur_byte = hex_ascii(digits[7:4]);
      3'd3:    cur_byte = hex_ascii(digits[3:0]);
      3'd4:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  assign bit_end   = (baud_cnt == BAUD_MAX);
  assign dbg_state = state;

  // Handshake: i_start is a single-cycle request, taken only on a cycle where
  // the block sits in IDLE (o_idle = 1). A request in any other state is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 3'd0;
      digits   <= 16'h0000;
      o_txd    <= 1'b1;
      o_idle   <= 1'b1;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            digits   <= i_digits;
            byte_idx <= 3'd0;
            bit_idx  <= 3'd0;
            baud_cnt <= '0;
            state    <= ST_START;
            o_txd    <= 1'b0;
            o_idle   <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            state    <= ST_DATA;
            o_txd    <= cur_byte[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              o_txd <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              o_txd   <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            // The next start bit follows the stop bit directly, with no idle gap.
            if (byte_idx == 3'd5) begin
              state  <= ST_IDLE;
              o_idle <= 1'b1;
              o_done <= 1'b1;
              o_txd  <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= ST_START;
              o_txd    <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
